main_ctrl_unit: RTL and testbench

// - Main + ALU control decoder for the single-cycle MIPS datapath (h_CPU).
// - Decodes the instruction OpCode/Funct fields into datapath steering signals and a 4-bit ALU operation.
// - Outputs are registered, so they are valid one clock after the instruction fields are presented.
// - Sits between instruction fetch and the register file, ALU and data memory.

---
 rtl/main_ctrl_unit_if.sv | 29 ++
 rtl/main_ctrl_unit.sv | 118 +++++++++++
 tb/tb_main_ctrl_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/main_ctrl_unit_if.sv
// Instruction-field / control-signal bundle between fetch (master) and the
// main control decoder (slave).
interface main_ctrl_unit_if;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       RegDst;
    logic       ALUSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       MemRead;
    logic       MemtoReg;
    logic       Branch;
    logic       Jump;
    logic [3:0] ALUCtr;
    logic       Link;
    logic       Illegal;

    modport master (
        output OpCode, Funct,
        input  RegDst, ALUSrc, RegWrite, MemWrite, MemRead, MemtoReg,
               Branch, Jump, ALUCtr, Link, Illegal
    );

    modport slave (
        input  OpCode, Funct,
        output RegDst, ALUSrc, RegWrite, MemWrite, MemRead, MemtoReg,
               Branch, Jump, ALUCtr, Link, Illegal
    );
endinterface

// File: rtl/main_ctrl_unit.sv
// Main + ALU control decoder for the single-cycle MIPS datapath; outputs are
// registered (1-cycle latency). Define CTR_JAL_EN to decode jal (000011).
module main_ctrl_unit (
    input  logic            clk,
    input  logic            rst_n,
    main_ctrl_unit_if.slave ctrl
);
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic [3:0] alu_ctr;
        logic       link;
        logic       illegal;
    } ctrl_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_LUI = 4'b1000;

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    always_comb begin
        ctrl_d = '0;
        unique case (ctrl.OpCode)
            6'b000000: begin
                ctrl_d.reg_dst   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                unique case (ctrl.Funct)
                    6'b100000, 6'b100001: ctrl_d.alu_ctr = ALU_ADD;
                    6'b100010, 6'b100011: ctrl_d.alu_ctr = ALU_SUB;
                    6'b100100:            ctrl_d.alu_ctr = ALU_AND;
                    6'b100101:            ctrl_d.alu_ctr = ALU_OR;
                    6'b100111:            ctrl_d.alu_ctr = ALU_NOR;
                    6'b101010:            ctrl_d.alu_ctr = ALU_SLT;
                    default: begin
                        ctrl_d         = '0;
                        ctrl_d.illegal = 1'b1;
                    end
                endcase
            end
            6'b100011: begin
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_ctr    = ALU_ADD;
            end
            6'b101011: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_ctr   = ALU_ADD;
            end
            6'b000100: begin
                ctrl_d.branch  = 1'b1;
                ctrl_d.alu_ctr = ALU_SUB;
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001111: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                unique case (ctrl.OpCode)
                    6'b001100: ctrl_d.alu_ctr = ALU_AND;
                    6'b001101: ctrl_d.alu_ctr = ALU_OR;
                    6'b001010: ctrl_d.alu_ctr = ALU_SLT;
                    6'b001111: ctrl_d.alu_ctr = ALU_LUI;
                    default:   ctrl_d.alu_ctr = ALU_ADD;
                endcase
            end
            6'b000010: ctrl_d.jump = 1'b1;
`ifdef CTR_JAL_EN
            6'b000011: begin
                ctrl_d.jump      = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.link      = 1'b1;
                ctrl_d.alu_ctr   = ALU_ADD;
            end
`endif
            default: ctrl_d.illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign ctrl.RegDst   = ctrl_q.reg_dst;
    assign ctrl.ALUSrc   = ctrl_q.alu_src;
    assign ctrl.RegWrite = ctrl_q.reg_write;
    assign ctrl.MemWrite = ctrl_q.mem_write;
    assign ctrl.MemRead  = ctrl_q.mem_read;
    assign ctrl.MemtoReg = ctrl_q.mem_to_reg;
    assign ctrl.Branch   = ctrl_q.branch;
    assign ctrl.Jump     = ctrl_q.jump;
    assign ctrl.ALUCtr   = ctrl_q.alu_ctr;
`ifdef CTR_JAL_EN
    assign ctrl.Link     = ctrl_q.link;
`else
    // Link bit in the register is never set here; drive a hard 0 regardless.
    assign ctrl.Link     = 1'b0;
    logic unused_link;
    assign unused_link   = ctrl_q.link;
`endif
    assign ctrl.Illegal  = ctrl_q.illegal;
endmodule

// File: tb/tb_main_ctrl_unit.sv
// Self-checking bench for main_ctrl_unit: directed steps plus random opcodes
// checked against a table-driven instruction model.
module tb_main_ctrl_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    main_ctrl_unit_if bus ();

    main_ctrl_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result layout: RegDst ALUSrc RegWrite MemWrite MemRead MemtoReg Branch Jump ALUCtr[3:0] Link Illegal
    typedef struct {
        bit         rtype;
        logic [5:0] code;
        logic [13:0] res;
        string      name;
    } instr_t;

    instr_t tbl[$];
    logic [13:0] ILLEGAL_RES;

    function automatic logic [13:0] model(input logic [5:0] op, input logic [5:0] fn);
        bit is_r;
        is_r = (op == 6'b000000);
        foreach (tbl[i]) begin
            if (tbl[i].rtype == is_r && tbl[i].code == (is_r ? fn : op))
                return tbl[i].res;
        end
        return ILLEGAL_RES;
    endfunction

    function automatic logic [13:0] observed();
        return {bus.RegDst, bus.ALUSrc, bus.RegWrite, bus.MemWrite, bus.MemRead,
                bus.MemtoReg, bus.Branch, bus.Jump, bus.ALUCtr, bus.Link, bus.Illegal};
    endfunction

    task automatic check(input string tag, input logic [13:0] exp);
        logic [13:0] obs;
        logic        bad_combo;
        obs = observed();
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        bad_combo = bus.Illegal & (bus.RegWrite | bus.MemWrite);
        n_checks++;
        assert (bad_combo === 1'b0) else begin
            n_fail++;
            $error("FAIL %s_illegal_vs_write: observed %b expected 0", tag, bad_combo);
        end
    endtask

    // Present fields before an edge, check 1 ns after it, then wiggle inputs
    // mid-cycle and confirm the registered outputs hold.
    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn);
        logic [13:0] exp;
        exp = model(op, fn);
        bus.OpCode = op;
        bus.Funct  = fn;
        @(posedge clk);
        #1;
        check(tag, exp);
        $display("step %-10s op=%b fn=%b -> %b", tag, op, fn, observed());
        bus.OpCode = 6'($urandom);
        bus.Funct  = 6'($urandom);
        #2;
        check({tag, "_hold"}, exp);
    endtask

    initial begin
        logic [5:0] op, fn;
        n_checks = 0;
        n_fail   = 0;
        ILLEGAL_RES = 14'b0000_0000_0000_01;
        tbl.push_back('{1, 6'b100000, 14'b1010_0000_0010_00, "add"});
        tbl.push_back('{1, 6'b100001, 14'b1010_0000_0010_00, "addu"});
        tbl.push_back('{1, 6'b100010, 14'b1010_0000_0110_00, "sub"});
        tbl.push_back('{1, 6'b100011, 14'b1010_0000_0110_00, "subu"});
        tbl.push_back('{1, 6'b100100, 14'b1010_0000_0000_00, "and"});
        tbl.push_back('{1, 6'b100101, 14'b1010_0000_0001_00, "or"});
        tbl.push_back('{1, 6'b100111, 14'b1010_0000_1100_00, "nor"});
        tbl.push_back('{1, 6'b101010, 14'b1010_0000_0111_00, "slt"});
        tbl.push_back('{0, 6'b100011, 14'b0110_1100_0010_00, "lw"});
        tbl.push_back('{0, 6'b101011, 14'b0101_0000_0010_00, "sw"});
        tbl.push_back('{0, 6'b000100, 14'b0000_0010_0110_00, "beq"});
        tbl.push_back('{0, 6'b001000, 14'b0110_0000_0010_00, "addi"});
        tbl.push_back('{0, 6'b001100, 14'b0110_0000_0000_00, "andi"});
        tbl.push_back('{0, 6'b001101, 14'b0110_0000_0001_00, "ori"});
        tbl.push_back('{0, 6'b001010, 14'b0110_0000_0111_00, "slti"});
        tbl.push_back('{0, 6'b001111, 14'b0110_0000_1000_00, "lui"});
        tbl.push_back('{0, 6'b000010, 14'b0000_0001_0000_00, "j"});
`ifdef CTR_JAL_EN
        tbl.push_back('{0, 6'b000011, 14'b0010_0001_0010_10, "jal"});
`endif

        // Reset held: outputs stay 0 across edges with toggling inputs.
        rst_n = 1'b0;
        bus.OpCode = 6'b000000;
        bus.Funct  = 6'b100000;
        for (int i = 0; i < 4; i++) begin
            bus.OpCode = 6'($urandom);
            bus.Funct  = 6'($urandom);
            @(posedge clk);
            #1;
            check("reset_hold", 14'd0);
        end

        // Release between edges; first capture at the next posedge.
        bus.OpCode = 6'b000000;
        bus.Funct  = 6'b100000;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release", 14'd0);

        step("add",    6'b000000, 6'b100000);
        step("sub",    6'b000000, 6'b100010);
        step("lw",     6'b100011, 6'b111111);
        step("sw",     6'b101011, 6'b000000);
        step("beq",    6'b000100, 6'b100000);
        step("j",      6'b000010, 6'b101010);
        step("ill_op", 6'b111111, 6'b100000);
        step("ill_fn", 6'b000000, 6'b000001);
        step("jal",    6'b000011, 6'b000000);
        step("addi",   6'b001000, 6'b000000);
        step("andi",   6'b001100, 6'b000000);
        step("ori",    6'b001101, 6'b000000);
        step("slti",   6'b001010, 6'b000000);
        step("lui",    6'b001111, 6'b000000);
        step("nor",    6'b000000, 6'b100111);
        step("addu",   6'b000000, 6'b100001);

        // Asynchronous reset assertion mid-cycle clears outputs immediately.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset", 14'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                int k;
                k  = $urandom_range(0, tbl.size() - 1);
                op = tbl[k].rtype ? 6'b000000 : tbl[k].code;
                fn = tbl[k].rtype ? tbl[k].code : 6'($urandom);
            end else begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            step("rand", op, fn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
